restoring_divider: RTL and testbench
====================================

# restoring_divider

Sequential signed integer divider, the inverse companion to the team's Booth multiplier. Operands arrive over one shared `data_in` bus in two consecutive cycles after `start`: dividend first, then divisor. A controller FSM drives a restoring shift/subtract datapath for `W` iterations, then applies the sign correction. The quotient and remainder are then held stable with `done` high.

## Interface
- `W`, default 16: operand and result width; two's-complement signed.
- `clk`  in  1: sole clock, rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `data_in`  in  W: operand bus; dividend in LOAD_A, divisor in LOAD_B.
- `quotient`  out  W: signed quotient, truncated toward zero.
- `remainder`  out  W: signed remainder; sign follows the dividend.
- `done`  out  1: level; results valid.
- `busy`  out  1: high in every state except IDLE.
- `div_by_zero`  out  1: last operation had a zero divisor; valid with `done`.

## Operation
- States and transitions:
  - IDLE: `start`=1 -> LOAD_A.
  - LOAD_A: capture dividend -> LOAD_B.
  - LOAD_B: capture divisor. Divisor 0 -> IDLE with the error result. Otherwise -> CALC with count=W.
  - CALC: one iteration per cycle, count decrements; count reaching 0 -> FIX.
  - FIX: sign correction, results registered -> IDLE with `done`=1.
- LOAD_B also records the operand signs:
  - sign_q = sign(dividend) XOR sign(divisor).
  - sign_r = sign(dividend).
  - Magnitudes are held in W+1-bit unsigned registers, so |-2^(W-1)| is representable.
- CALC step, with partial remainder P (W+1 bits), dividend magnitude register Q, and divisor magnitude D:
  - Shift {P,Q} left one bit.
  - T = P - D.
  - T non-negative -> P=T, Q[0]=1. Otherwise P is unchanged (restored) and Q[0]=0.
- FIX:
  - quotient = sign_q ? -Q : Q, truncated to W bits.
  - remainder = sign_r ? -P : P, truncated to W bits.
- Divide-by-zero result: quotient = all ones, remainder = dividend, `div_by_zero`=1.
- Overflow case -2^(W-1) / -1: quotient wraps to 0x8000 (W=16), remainder = 0. No flag is raised.
- `done` rules:
  - Cleared on the edge that accepts `start`.
  - Otherwise held high, with results stable, until the next accepted start.
- `div_by_zero` clears with `done`.
- `start` while busy is ignored and has no effect on the operation in progress.
- Reset has priority at any time, including mid-CALC.

## Timing
- Edge e0: `start` sampled in IDLE. Then e1 captures the dividend and e2 captures the divisor.
- Edges e3..e(W+2): W CALC iterations.
- Edge e(W+3): FIX. `done` goes high after e(W+3), i.e. 19 edges after e0 for W=16.
- Divide by zero: `done` and `div_by_zero` go high after e2.
- `busy` is high from after e0 until the edge that raises `done`. `busy` and `done` are never both high.
- Back-to-back: `start` held high while `done`=1 is accepted on the next edge. A new operation can begin one cycle after `done` rises.
- Reset values (asynchronous, immediate, independent of `clk`):
  - State = IDLE.
  - `quotient`=0, `remainder`=0.
  - `done`=0, `busy`=0, `div_by_zero`=0.
  - All internal registers 0.
- Outputs are registered; there are no combinational paths from `data_in` or `start` to any output.

## Test plan
- Basic: start, then `data_in`=17, then 5 -> after 19 edges, `quotient`=3, `remainder`=2, `done`=1, `div_by_zero`=0.
- Signs:
  - -17/5 -> -3 rem -2.
  - 17/-5 -> -3 rem 2.
  - -17/-5 -> 3 rem -2.
  - 4/7 -> 0 rem 4.
- Edges of range:
  - -32768/-1 -> 0x8000 rem 0.
  - -32768/1 -> 0x8000 rem 0.
  - 32767/32767 -> 1 rem 0.
  - 0/9 -> 0 rem 0.
- Divide by zero: 7/0 -> after e2, `done`=1, `div_by_zero`=1, `quotient`=0xFFFF, `remainder`=7. The next valid operation clears the flag.
- Control:
  - Pulsing `start` during CALC changes nothing; 100/7 -> 14 rem 2.
  - Back-to-back 100/7 then 9/3 -> 3 rem 0, each with correct latency.
- Reset: assert `rst_n`=0 mid-CALC, asynchronously between edges -> all outputs 0 immediately. After release, 17/5 completes correctly.

Source files
------------

// File: rtl/restoring_divider.sv
// Sequential signed divider: operands arrive on a shared bus, a restoring
// shift/subtract loop runs W iterations, then the signs are re-applied.
module restoring_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CALC,
    S_FIX
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  q_q, q_d;
  logic [W:0]    p_q, p_d;
  logic [W:0]    d_q, d_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    p_shift;
  logic [W+1:0]  diff;

  // The partial remainder stays below the divisor magnitude, so only its
  // low W bits carry into the shift; the extra bit absorbs |-2^(W-1)|.
  assign p_shift = {p_q[W-1:0], q_q[W-1]};
  assign diff    = {1'b0, p_shift} - {1'b0, d_q};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    a_d       = a_q;
    q_d       = q_q;
    p_d       = p_q;
    d_d       = d_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    done_d    = done_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          done_d  = 1'b0;
          dbz_d   = 1'b0;
        end
      end
      S_LOAD_A: begin
        a_d     = data_in;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        neg_quo_d = a_q[W-1] ^ data_in[W-1];
        neg_rem_d = a_q[W-1];
        q_d       = a_q[W-1] ? -a_q : a_q;
        p_d       = '0;
        d_d       = data_in[W-1] ? -{data_in[W-1], data_in} : {1'b0, data_in};
        count_d   = CW'(W);
        if (data_in == '0) begin
          quo_d   = '1;
          rem_d   = a_q;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        q_d     = {q_q[W-2:0], ~diff[W+1]};
        p_d     = diff[W+1] ? p_shift : diff[W:0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quo_d   = neg_quo_q ? -q_q : q_q;
        rem_d   = W'(neg_rem_q ? -p_q : p_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      a_q       <= '0;
      q_q       <= '0;
      p_q       <= '0;
      d_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      a_q       <= a_d;
      q_q       <= q_d;
      p_q       <= p_d;
      d_q       <= d_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks of restoring_divider against plain signed
// integer division; one line is printed per operation.
module tb_restoring_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] quotient, remainder;
  logic        done, busy, div_by_zero;

  int errors = 0;
  int checks = 0;

  restoring_divider #(.W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data_in(data_in),
    .quotient(quotient),
    .remainder(remainder),
    .done(done),
    .busy(busy),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned just after a falling edge; returns likewise.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit pulse);
    int          sa, sb, edges, exp_lat;
    logic [15:0] eq, er;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      eq = 16'hFFFF;
      er = a;
      exp_lat = 0;
    end else begin
      eq = 16'(sa / sb);
      er = 16'(sa % sb);
      exp_lat = 17;
    end
    start = 1'b1;
    data_in = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    data_in = a;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_cleared", 32'(done), 32'd0);
    chk("dbz_cleared", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    @(negedge clk);
    data_in = b;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'($urandom);
    edges = 0;
    while (!done && edges < 40) begin
      start = pulse && (edges == 5);
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    chk("latency", 32'(edges), 32'(exp_lat));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(sb == 0));
    chk("busy_with_done", 32'(busy), 32'd0);
    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d", sa, sb,
             $signed(quotient), $signed(remainder), div_by_zero, edges);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'd17, 16'd5, 1'b0);
    run_op(-16'sd17, 16'd5, 1'b0);
    run_op(16'd17, -16'sd5, 1'b0);
    run_op(-16'sd17, -16'sd5, 1'b0);
    run_op(16'd4, 16'd7, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0);
    run_op(16'h8000, 16'd1, 1'b0);
    run_op(16'd32767, 16'd32767, 1'b0);
    run_op(16'd0, 16'd9, 1'b0);
    run_op(16'd7, 16'd0, 1'b0);
    run_op(16'd100, 16'd7, 1'b1);
    run_op(16'd100, 16'd7, 1'b0);
    run_op(16'd9, 16'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op(16'($urandom), 16'($urandom_range(0, 65535)), 1'(i % 5 == 0));
    end
    run_op(16'($urandom), 16'($urandom_range(1, 3)), 1'b0);
    run_op(16'd9, 16'd3, 1'b0);

    // Abort an operation mid-iteration with an asynchronous reset.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    data_in = 16'd100;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd7;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midcalc_reset_quotient", 32'(quotient), 32'd0);
    chk("midcalc_reset_remainder", 32'(remainder), 32'd0);
    chk("midcalc_reset_done", 32'(done), 32'd0);
    chk("midcalc_reset_busy", 32'(busy), 32'd0);
    chk("midcalc_reset_dbz", 32'(div_by_zero), 32'd0);
    $display("reset asserted mid-calculation");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd17, 16'd5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
